race_state_controller: RTL
==========================

Name: race_state_controller

Overview:
Top-level game sequencer that produces the 3-bit `state` code consumed by PhysicsEngine and other state-aware blocks. It runs the IDLE/SETTING/COUNTDOWN/RACING/PAUSE/FINISH flow from debounced button pulses and generates the countdown and race-time second ticks. It also closes the loop on the car's `pos_x`/`pos_y` (the engine's outputs) to count laps and declare FINISH.

Parameters:
TICK_DIV, 100000000, clock cycles per one-second tick (bench uses 4)
COUNTDOWN_SEC, 3, countdown start value in seconds (1..15)
LAPS, 3, laps required to finish (1..7)
FIN_X_MIN, 140, finish box left edge, inclusive
FIN_X_MAX, 180, finish box right edge, inclusive
FIN_Y_MIN, 200, finish box top, inclusive
FIN_Y_MAX, 204, finish box bottom, inclusive
CHK_Y_MAX, 40, checkpoint region is pos_y <= CHK_Y_MAX (any x)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
start_btn  in  1  one-cycle pulse, debounced upstream
pause_btn  in  1  one-cycle pulse, debounced upstream
pos_x  in  10  car x from the physics stage
pos_y  in  10  car y from the physics stage
state  out  3  IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6
countdown  out  4  seconds remaining, valid in COUNTDOWN
lap  out  3  completed laps
race_time  out  10  elapsed race seconds, saturates at 999
sec_tick  out  1  one-cycle pulse on each second boundary

Behaviour:
- All regs async-reset on rst=0: state=IDLE, countdown=0, lap=0, race_time=0, sec_tick=0, prescaler=0, chk_seen=0, in_fin_q=0. Outputs are registered and change one cycle after the causing input.
- Prescaler counts 0..TICK_DIV-1 only in COUNTDOWN and RACING. sec_tick=1 on the cycle after it wraps. It is frozen in PAUSE and cleared to 0 on every entry to COUNTDOWN or RACING.
- IDLE: start_btn -> SETTING. Clear lap and race_time.
- SETTING: start_btn -> COUNTDOWN. Load countdown=COUNTDOWN_SEC, clear chk_seen.
- COUNTDOWN: each tick decrements countdown. On the tick where countdown==1: countdown<=0 and state<=RACING in the same cycle. pause_btn is ignored.
- RACING:
  - Each tick: race_time+1, saturating at 999.
  - chk_seen<=1 whenever pos_y<=CHK_Y_MAX.
  - in_fin = pos inside the finish box (all four bounds inclusive). in_fin_q is registered every cycle in all states.
  - A lap is counted on the in_fin rising edge (in_fin & ~in_fin_q) with chk_seen=1: lap+1, chk_seen<=0.
  - If the new lap==LAPS -> FINISH.
  - Otherwise pause_btn -> PAUSE.
- PAUSE: pause_btn -> RACING. All counters, lap, chk_seen and race_time hold. start_btn is ignored.
- FINISH: hold lap and race_time for display. start_btn -> IDLE.
- Priorities:
  - Lap completion reaching LAPS beats pause_btn in the same cycle.
  - A tick and a lap in the same cycle both take effect.
  - start_btn is ignored in COUNTDOWN, RACING and PAUSE.
  - Simultaneous start_btn and pause_btn: only the one legal in the current state acts.
- Starting on the finish line does not count a lap, because chk_seen is cleared on COUNTDOWN entry.
- Unused codes 2 and 7 recover to IDLE on the next clock.
- Reset asserted mid-race returns to IDLE immediately (asynchronously).

Test Plan:
- Reset, then start, start with TICK_DIV=4 and COUNTDOWN_SEC=3 -> state 0->1->3. countdown 3,2,1 with a tick every 4 cycles. state=4 with countdown=0 on the third tick.
- In RACING, drive pos_y=30 then pos=(160,202) -> lap=1. Re-enter the box without revisiting y<=40 -> lap stays 1.
- Three valid laps with LAPS=3 -> state=6. race_time freezes. start_btn -> state=0. A second start clears lap to 0.
- pause_btn at race_time=5 -> state=5. Hold 20 cycles: race_time=5, prescaler frozen. pause_btn -> 4, and the next tick arrives 4 cycles later.
- Third lap edge and pause_btn in the same cycle -> state=6, not 5.
- Run 1000+ ticks in RACING -> race_time saturates at 999. Assert rst=0 mid-cycle -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/race_state_controller.sv
// Game sequencer: drives the IDLE/SETTING/COUNTDOWN/RACING/PAUSE/FINISH flow,
// generates one-second ticks and counts laps from the car position.
module race_state_controller #(
  parameter int TICK_DIV      = 100000000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int LAPS          = 3,
  parameter int FIN_X_MIN     = 140,
  parameter int FIN_X_MAX     = 180,
  parameter int FIN_Y_MIN     = 200,
  parameter int FIN_Y_MAX     = 204,
  parameter int CHK_Y_MAX     = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic [2:0] state,
  output logic [3:0] countdown,
  output logic [2:0] lap,
  output logic [9:0] race_time,
  output logic       sec_tick
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTING   = 3'd1,
    S_COUNTDOWN = 3'd3,
    S_RACING    = 3'd4,
    S_PAUSE     = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  P_LAST   = PW'(TICK_DIV - 1);
  localparam logic [3:0]     CD_INIT  = 4'(COUNTDOWN_SEC);
  localparam logic [2:0]     LAP_DONE = 3'(LAPS);
  localparam logic [9:0]     RT_MAX   = 10'd999;
  localparam logic [9:0]     FX_MIN   = 10'(FIN_X_MIN);
  localparam logic [9:0]     FX_MAX   = 10'(FIN_X_MAX);
  localparam logic [9:0]     FY_MIN   = 10'(FIN_Y_MIN);
  localparam logic [9:0]     FY_MAX   = 10'(FIN_Y_MAX);
  localparam logic [9:0]     CY_MAX   = 10'(CHK_Y_MAX);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_countdown;
  logic [2:0]    r_lap;
  logic [9:0]    r_race_time;
  logic          r_sec_tick;
  logic          r_chk_seen;
  logic          r_in_fin_q;

  state_t        w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [3:0]    w_countdown_nxt;
  logic [2:0]    w_lap_nxt;
  logic [9:0]    w_race_time_nxt;
  logic          w_chk_seen_nxt;

  logic          w_counting;
  logic          w_tick;
  logic          w_in_fin;
  logic          w_in_chk;
  logic          w_lap_evt;
  logic [2:0]    w_lap_inc;

  assign w_counting = (r_state == S_COUNTDOWN) || (r_state == S_RACING);
  assign w_tick     = w_counting && (r_presc == P_LAST);
  assign w_in_fin   = (pos_x >= FX_MIN) && (pos_x <= FX_MAX) &&
                      (pos_y >= FY_MIN) && (pos_y <= FY_MAX);
  assign w_in_chk   = (pos_y <= CY_MAX);
  // A lap needs a fresh entry into the finish box after visiting the checkpoint.
  assign w_lap_evt  = (r_state == S_RACING) && w_in_fin && !r_in_fin_q && r_chk_seen;
  assign w_lap_inc  = r_lap + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_countdown_nxt = r_countdown;
    w_lap_nxt       = r_lap;
    w_race_time_nxt = r_race_time;
    w_chk_seen_nxt  = r_chk_seen;

    if (w_counting) begin
      w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (start_btn) begin
          w_state_nxt     = S_SETTING;
          w_lap_nxt       = '0;
          w_race_time_nxt = '0;
        end
      end
      S_SETTING: begin
        if (start_btn) begin
          w_state_nxt     = S_COUNTDOWN;
          w_countdown_nxt = CD_INIT;
          w_chk_seen_nxt  = 1'b0;
          w_presc_nxt     = '0;
        end
      end
      S_COUNTDOWN: begin
        if (w_tick) begin
          if (r_countdown <= 4'd1) begin
            w_countdown_nxt = '0;
            w_state_nxt     = S_RACING;
            w_presc_nxt     = '0;
          end else begin
            w_countdown_nxt = r_countdown - 4'd1;
          end
        end
      end
      S_RACING: begin
        if (w_tick && (r_race_time != RT_MAX)) begin
          w_race_time_nxt = r_race_time + 10'd1;
        end
        if (w_lap_evt) begin
          w_lap_nxt      = w_lap_inc;
          w_chk_seen_nxt = 1'b0;
        end else if (w_in_chk) begin
          w_chk_seen_nxt = 1'b1;
        end
        // Finishing wins over a pause requested in the same cycle.
        if (w_lap_evt && (w_lap_inc == LAP_DONE)) begin
          w_state_nxt = S_FINISH;
        end else if (pause_btn) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_btn) begin
          w_state_nxt = S_RACING;
          w_presc_nxt = '0;
        end
      end
      S_FINISH: begin
        if (start_btn) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc     <= '0;
      r_countdown <= '0;
      r_lap       <= '0;
      r_race_time <= '0;
      r_sec_tick  <= 1'b0;
      r_chk_seen  <= 1'b0;
      r_in_fin_q  <= 1'b0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_countdown <= w_countdown_nxt;
      r_lap       <= w_lap_nxt;
      r_race_time <= w_race_time_nxt;
      r_sec_tick  <= w_tick;
      r_chk_seen  <= w_chk_seen_nxt;
      r_in_fin_q  <= w_in_fin;
    end
  end

  assign state     = r_state;
  assign countdown = r_countdown;
  assign lap       = r_lap;
  assign race_time = r_race_time;
  assign sec_tick  = r_sec_tick;

endmodule
